// File: rtl/ser2par_pkg.sv
// Shared constants and the output-state encoding for the serial-to-parallel stage.
package ser2par_pkg;

    localparam int SER2PAR_WIDTH_DEF = 8;

    // Bit-order selectors for the MSB_FIRST parameter.
    localparam bit BIT_MSB_FIRST = 1'b1;
    localparam bit BIT_LSB_FIRST = 1'b0;

    // Output register occupancy; FULL means q holds an undelivered word.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/ser2par_shift_core.sv
// Shift register plus bit counter. Presents the word that would result from the
// current accept (next_word) and flags when that accept completes a word.
module ser2par_shift_core
    import ser2par_pkg::*;
#(
    parameter int WIDTH     = SER2PAR_WIDTH_DEF,
    parameter bit MSB_FIRST = BIT_MSB_FIRST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     accept,
    input  logic                     d,
    input  logic                     clear,
    output logic                     word_done,
    output logic [WIDTH-1:0]         next_word,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;

    // Bit order decides which end of the register the new bit enters.
    generate
        if (MSB_FIRST == BIT_MSB_FIRST) begin : g_msb
            assign next_word = {sh[WIDTH-2:0], d};
        end else begin : g_lsb
            assign next_word = {d, sh[WIDTH-1:1]};
        end
    endgenerate

    assign word_done = accept && (cnt == CNT_LAST);
    assign bit_cnt   = cnt;

    // Shift on accept; clear (preset) throws away the partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sh  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sh  <= next_word;
            cnt <= word_done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ser2par_reg.sv
// Serial-to-parallel register stage: assembles WIDTH-bit words from a serial
// stream and offers them downstream, with word-level preset and parallel load.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high and ready is low;
// ready may depend combinationally on the current state and side-band controls.
module ser2par_reg
    import ser2par_pkg::*;
#(
    parameter int WIDTH     = SER2PAR_WIDTH_DEF,
    parameter bit MSB_FIRST = BIT_MSB_FIRST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d,
    input  logic                     d_valid,
    output logic                     d_ready,
    input  logic                     preset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_data,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    out_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_d;
    logic             overrun_d;
    logic             accept;
    logic             word_done;
    logic [WIDTH-1:0] next_word;

    // The completing bit is refused only while the held word is stuck; if it
    // drains this cycle the new word can take its place at the same edge.
    assign d_ready = !preset && !load
                     && !((bit_cnt == CNT_LAST) && (state_q == OUT_FULL) && !q_ready);
    assign accept  = d_valid && d_ready;
    assign q_valid = (state_q == OUT_FULL);

    ser2par_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .d         (d),
        .clear     (preset),
        .word_done (word_done),
        .next_word (next_word),
        .bit_cnt   (bit_cnt)
    );

    // Next output word and occupancy: preset > load > completed word > drain.
    always_comb begin
        state_d   = state_q;
        q_d       = q;
        overrun_d = 1'b0;
        if (preset) begin
            q_d       = '1;
            state_d   = OUT_FULL;
            overrun_d = (state_q == OUT_FULL) && !q_ready;
        end else if (load) begin
            q_d       = load_data;
            state_d   = OUT_FULL;
            overrun_d = (state_q == OUT_FULL) && !q_ready;
        end else if (word_done) begin
            q_d     = next_word;
            state_d = OUT_FULL;
        end else if ((state_q == OUT_FULL) && q_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    // Output word, occupancy state and the overrun pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            q       <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            q       <= q_d;
            overrun <= overrun_d;
        end
    end

endmodule

// File: tb/tb_ser2par_reg.sv
// Bench for ser2par_reg: one MSB-first and one LSB-first instance (WIDTH = 4)
// share a stimulus stream and are compared against a bit-list word model.
module tb_ser2par_reg;
  import ser2par_pkg::*;

  localparam int W  = 4;
  localparam int CW = $clog2(W);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          d, d_valid, preset, load, q_ready;
  logic [W-1:0]  load_data;
  logic          msb_d_ready, lsb_d_ready;
  logic [W-1:0]  msb_q, lsb_q;
  logic          msb_q_valid, lsb_q_valid;
  logic [CW-1:0] msb_bit_cnt, lsb_bit_cnt;
  logic          msb_overrun, lsb_overrun;

  ser2par_reg #(.WIDTH(W), .MSB_FIRST(BIT_MSB_FIRST)) dut_msb (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(msb_d_ready),
    .preset(preset), .load(load), .load_data(load_data), .q(msb_q),
    .q_valid(msb_q_valid), .q_ready(q_ready), .bit_cnt(msb_bit_cnt),
    .overrun(msb_overrun)
  );

  ser2par_reg #(.WIDTH(W), .MSB_FIRST(BIT_LSB_FIRST)) dut_lsb (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(lsb_d_ready),
    .preset(preset), .load(load), .load_data(load_data), .q(lsb_q),
    .q_valid(lsb_q_valid), .q_ready(q_ready), .bit_cnt(lsb_bit_cnt),
    .overrun(lsb_overrun)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Received bits of the partial word in arrival order; the word is formed
  // arithmetically once W bits have arrived.
  int           m_bits[$];
  logic [W-1:0] m_q_msb, m_q_lsb;
  logic         m_qv, m_ovr;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q_lsb[$];

  task automatic model_reset();
    m_bits.delete();
    m_q_msb = '0;
    m_q_lsb = '0;
    m_qv    = 1'b0;
    m_ovr   = 1'b0;
    exp_q.delete();
    exp_q_lsb.delete();
  endtask

  task automatic check_outputs();
    check("msb_q",       32'(msb_q),       32'(m_q_msb));
    check("lsb_q",       32'(lsb_q),       32'(m_q_lsb));
    check("msb_q_valid", 32'(msb_q_valid), 32'(m_qv));
    check("lsb_q_valid", 32'(lsb_q_valid), 32'(m_qv));
    check("msb_bit_cnt", 32'(msb_bit_cnt), 32'(m_bits.size()));
    check("lsb_bit_cnt", 32'(lsb_bit_cnt), 32'(m_bits.size()));
    check("msb_overrun", 32'(msb_overrun), 32'(m_ovr));
    check("lsb_overrun", 32'(lsb_overrun), 32'(m_ovr));
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drives one cycle of inputs, checks d_ready, advances
  // the model across the edge and checks the registered outputs at posedge+1.
  task automatic cycle(input logic bd, input logic bv, input logic bp, input logic bl,
                       input logic [W-1:0] bld, input logic bqr);
    logic         exp_dr, acc, refill, ovr_n;
    logic [W-1:0] wm, wl;
    d = bd; d_valid = bv; preset = bp; load = bl; load_data = bld; q_ready = bqr;
    #1;
    exp_dr = !bp && !bl && !((m_bits.size() == W - 1) && m_qv && !bqr);
    check("msb_d_ready", 32'(msb_d_ready), 32'(exp_dr));
    check("lsb_d_ready", 32'(lsb_d_ready), 32'(exp_dr));

    // Scoreboard: a word leaving the stage must be the oldest expected word;
    // a word overwritten while stalled is dropped.
    if (m_qv && bqr) begin
      if (exp_q.size() > 0)     check("sb_msb_word", 32'(msb_q), 32'(exp_q.pop_front()));
      if (exp_q_lsb.size() > 0) check("sb_lsb_word", 32'(lsb_q), 32'(exp_q_lsb.pop_front()));
    end else if (m_qv && (bp || bl)) begin
      if (exp_q.size() > 0)     void'(exp_q.pop_front());
      if (exp_q_lsb.size() > 0) void'(exp_q_lsb.pop_front());
    end

    acc    = bv && exp_dr;
    ovr_n  = (bp || bl) && m_qv && !bqr;
    refill = 1'b0;
    if (bp) begin
      m_bits.delete();
      m_q_msb = '1;
      m_q_lsb = '1;
      refill  = 1'b1;
    end else if (bl) begin
      m_q_msb = bld;
      m_q_lsb = bld;
      refill  = 1'b1;
    end else if (acc) begin
      m_bits.push_back(int'(bd));
      if (m_bits.size() == W) begin
        wm = '0;
        wl = '0;
        for (int i = 0; i < W; i++) begin
          wm = (wm << 1) | W'(m_bits[i]);
          wl = wl | (W'(m_bits[i]) << i);
        end
        m_q_msb = wm;
        m_q_lsb = wl;
        m_bits.delete();
        refill = 1'b1;
      end
    end
    if (refill) begin
      m_qv = 1'b1;
      exp_q.push_back(m_q_msb);
      exp_q_lsb.push_back(m_q_lsb);
    end else if (m_qv && bqr) begin
      m_qv = 1'b0;
    end
    m_ovr = ovr_n;

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic bd, input logic bqr);
    cycle(bd, 1'b1, 1'b0, 1'b0, '0, bqr);
  endtask

  task automatic idle(input logic bqr);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, bqr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; d = 1'b0; d_valid = 1'b0; preset = 1'b0; load = 1'b0;
    load_data = '0; q_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // Basic MSB-first word, drained immediately.
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
    check("t1_word", 32'(msb_q), 32'h0000_000b);
    idle(1'b1);

    // Stall: hold 1011, three more bits accepted, fourth refused until drain.
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    check("t2_cnt3", 32'(msb_bit_cnt), 32'd3);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    check("t2_word", 32'(msb_q), 32'h0000_0006);

    // Load and preset+load overwriting a stalled word.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0);
    check("t3_load", 32'(msb_q), 32'h0000_000a);
    idle(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0);
    check("t3_preset", 32'(msb_q), 32'h0000_000f);
    idle(1'b0);

    // Preset discards a partial word.
    idle(1'b1);
    send(1'b1, 1'b1); send(1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    check("t4_word", 32'(msb_q), 32'h0000_0001);

    // Asynchronous reset between edges with a partial word and a held word.
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_q",   32'(msb_q),       32'd0);
    check("t5_rst_qv",  32'(msb_q_valid), 32'd0);
    check("t5_rst_cnt", 32'(msb_bit_cnt), 32'd0);
    check("t5_rst_lsb", 32'(lsb_q),       32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1);
    check("t5_word", 32'(msb_q), 32'h0000_000c);

    // Bit order: 1,0,0,0 lands in q[0] for LSB-first, q[3] for MSB-first.
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1);
    check("t6_lsb_word", 32'(lsb_q), 32'h0000_0001);
    check("t6_msb_word", 32'(msb_q), 32'h0000_0008);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 11) == 0,
            W'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
